fetch_unit: RTL

//  IF stage for the 5-stage MIPS pipeline. Owns the fetch PC, issues one

---
 rtl/imem_if.sv | 14 +
 rtl/fetch_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/imem_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
// One request is outstanding at a time; each accepted request returns exactly one word.
interface imem_if;
  localparam int unsigned XLEN = 32;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;

  modport master (output req_valid, addr, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_unit.sv
// IF stage of the 5-stage MIPS pipeline: owns pc_F, fetches one word at a time
// over imem_if and loads the IF/ID register, with a one-entry skid for decode stalls.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall_D,
  imem_if.master      imem,
  output logic        valid_D,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc_D4
);
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DROP} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_instr_q, id_instr_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_pc4_q, id_pc4_d;
  logic            req_valid_q, req_valid_d;

  logic            handshake;
  logic            load;
  logic [XLEN-1:0] load_instr;
  logic [XLEN-1:0] load_pc;

  assign handshake = req_valid_q & imem.req_ready;

  // Next-state, fetch PC, skid and IF/ID update; redirect pre-empts everything else.
  always_comb begin
    state_d      = state_q;
    pc_f_d       = pc_f_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    id_pc4_d     = id_pc4_q;
    load         = 1'b0;
    load_instr   = '0;
    load_pc      = '0;

    if (redirect) begin
      pc_f_d       = redirect_pc;
      id_valid_d   = 1'b0;
      skid_instr_d = '0;
      skid_pc_d    = '0;
      case (state_q)
        ISSUE:   state_d = handshake ? DROP : ISSUE;
        WAIT:    state_d = imem.rsp_valid ? ISSUE : DROP;
        HOLD:    state_d = ISSUE;
        DROP:    state_d = imem.rsp_valid ? ISSUE : DROP;
        default: state_d = ISSUE;
      endcase
    end else begin
      if (!stall_D) begin
        id_valid_d = 1'b0;
      end
      case (state_q)
        ISSUE: begin
          if (handshake) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (imem.rsp_valid) begin
            pc_f_d = pc_f_q + PC_STEP;
            if (!id_valid_q || !stall_D) begin
              load       = 1'b1;
              load_instr = imem.rsp_data;
              load_pc    = pc_f_q;
              state_d    = ISSUE;
            end else begin
              skid_instr_d = imem.rsp_data;
              skid_pc_d    = pc_f_q;
              state_d      = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_D) begin
            load         = 1'b1;
            load_instr   = skid_instr_q;
            load_pc      = skid_pc_q;
            skid_instr_d = '0;
            skid_pc_d    = '0;
            state_d      = ISSUE;
          end
        end
        DROP: begin
          if (imem.rsp_valid) begin
            state_d = ISSUE;
          end
        end
        default: state_d = ISSUE;
      endcase
      if (load) begin
        id_valid_d = 1'b1;
        id_instr_d = load_instr;
        id_pc_d    = load_pc;
        id_pc4_d   = load_pc + PC_STEP;
      end
    end
  end

  // Request valid is registered so it reads low throughout reset.
  assign req_valid_d = (state_d == ISSUE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ISSUE;
      pc_f_q       <= RESET_PC;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= '0;
      id_pc_q      <= '0;
      id_pc4_q     <= '0;
      req_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_f_q       <= pc_f_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
      id_pc4_q     <= id_pc4_d;
      req_valid_q  <= req_valid_d;
    end
  end

  assign imem.req_valid = req_valid_q;
  assign imem.addr      = pc_f_q;
  assign valid_D        = id_valid_q;
  assign instr_D        = id_instr_q;
  assign pc_D           = id_pc_q;
  assign pc_D4          = id_pc4_q;
endmodule
